// File: rtl/memoredf_pkg.sv
// Shared types and helpers for the queue dispatcher: channel identifiers and queue one-hot decode.
package memoredf_pkg;

    typedef enum logic {
        CH1 = 1'b0,
        CH2 = 1'b1
    } channel_t;

    localparam int DEFAULT_NUMBER_OF_QUEUES = 4;
    localparam int QUEUE_ID_WIDTH           = $clog2(DEFAULT_NUMBER_OF_QUEUES);

    // Widest decode supported; callers truncate to their own queue count.
    localparam int MAX_QUEUES          = 64;
    localparam int MAX_QUEUE_ID_WIDTH  = $clog2(MAX_QUEUES);

    function automatic logic [MAX_QUEUES-1:0] onehot_queue(input logic [MAX_QUEUE_ID_WIDTH-1:0] id);
        return MAX_QUEUES'(1) << id;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin selector; last_grant only moves when the selected channel actually transfers.
module rr_arbiter_2
    import memoredf_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output channel_t   sel
);

    channel_t last_grant_q;
    channel_t other;

    always_comb begin
        other = (last_grant_q == CH1) ? CH2 : CH1;
        sel   = other;
        case (valid)
            2'b01:   sel = CH1;
            2'b10:   sel = CH2;
            default: sel = other;
        endcase
    end

    // Reset to CH2 so CH1 wins the first contention.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_grant_q <= CH2;
        end else if (advance) begin
            last_grant_q <= sel;
        end
    end

endmodule

// File: rtl/dispatcher_arbiter.sv
// Arbitrates two packetizers onto the shared queue-write port through a one-entry output stage.
// Optional statistics counters are compiled in with DISPATCHER_ARBITER_STATS_EN.
module dispatcher_arbiter
    import memoredf_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int DATA_SIZE        = 102 + (4 * 16) + (4 * 128),
    parameter int REGISTER_SIZE    = 32,
    localparam int ID_W            = $clog2(NUMBER_OF_QUEUES)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_SIZE-1:0]        packetizer_1_packet,
    input  logic                        packetizer_1_valid,
    input  logic [ID_W-1:0]             packetizer_1_id,
    output logic                        packetizer_1_ready,
    input  logic [DATA_SIZE-1:0]        packetizer_2_packet,
    input  logic                        packetizer_2_valid,
    input  logic [ID_W-1:0]             packetizer_2_id,
    output logic                        packetizer_2_ready,
    input  logic [NUMBER_OF_QUEUES-1:0] queues_ready,
    output logic [DATA_SIZE-1:0]        dispatcher_to_queues_packet,
    output logic [NUMBER_OF_QUEUES-1:0] dispatcher_to_queues_valid,
    output logic [ID_W-1:0]             dispatcher_to_queues_id,
    output logic [REGISTER_SIZE-1:0]    grant_count_1,
    output logic [REGISTER_SIZE-1:0]    grant_count_2,
    output logic [REGISTER_SIZE-1:0]    stall_count
);

    logic                 stage_full_q, stage_full_d;
    logic [DATA_SIZE-1:0] packet_q, packet_d;
    logic [ID_W-1:0]      id_q, id_d;

    logic     drain, load_en, xfer_1, xfer_2, transfer;
    channel_t sel;

    rr_arbiter_2 u_rr (
        .clock   (clock),
        .reset   (reset),
        .valid   ({packetizer_2_valid, packetizer_1_valid}),
        .advance (transfer),
        .sel     (sel)
    );

    // No bypass: a blocked head packet back-pressures both channels.
    assign drain   = stage_full_q && queues_ready[id_q];
    assign load_en = !stage_full_q || drain;

    assign packetizer_1_ready = load_en && (sel == CH1);
    assign packetizer_2_ready = load_en && (sel == CH2);
    assign xfer_1   = packetizer_1_valid && packetizer_1_ready;
    assign xfer_2   = packetizer_2_valid && packetizer_2_ready;
    assign transfer = xfer_1 || xfer_2;

    always_comb begin
        stage_full_d = stage_full_q;
        packet_d     = packet_q;
        id_d         = id_q;
        if (transfer) begin
            stage_full_d = 1'b1;
            if (sel == CH2) begin
                packet_d = packetizer_2_packet;
                id_d     = packetizer_2_id;
            end else begin
                packet_d = packetizer_1_packet;
                id_d     = packetizer_1_id;
            end
        end else if (drain) begin
            stage_full_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stage_full_q <= 1'b0;
            packet_q     <= '0;
            id_q         <= '0;
        end else begin
            stage_full_q <= stage_full_d;
            packet_q     <= packet_d;
            id_q         <= id_d;
        end
    end

    assign dispatcher_to_queues_packet = packet_q;
    assign dispatcher_to_queues_id     = id_q;
    assign dispatcher_to_queues_valid  = stage_full_q
        ? NUMBER_OF_QUEUES'(onehot_queue(MAX_QUEUE_ID_WIDTH'(id_q)))
        : '0;

`ifdef DISPATCHER_ARBITER_STATS_EN
    logic [REGISTER_SIZE-1:0] grant_1_q, grant_2_q, stall_q;

    // Saturating counters: they stick at all-ones rather than wrapping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            grant_1_q <= '0;
            grant_2_q <= '0;
            stall_q   <= '0;
        end else begin
            if (xfer_1 && (grant_1_q != '1)) grant_1_q <= grant_1_q + REGISTER_SIZE'(1);
            if (xfer_2 && (grant_2_q != '1)) grant_2_q <= grant_2_q + REGISTER_SIZE'(1);
            if (stage_full_q && !drain && (stall_q != '1)) stall_q <= stall_q + REGISTER_SIZE'(1);
        end
    end

    assign grant_count_1 = grant_1_q;
    assign grant_count_2 = grant_2_q;
    assign stall_count   = stall_q;
`else
    assign grant_count_1 = '0;
    assign grant_count_2 = '0;
    assign stall_count   = '0;
`endif

endmodule

// File: tb/tb_dispatcher_arbiter.sv
// Directed self-checking bench for dispatcher_arbiter; counter expectations follow DISPATCHER_ARBITER_STATS_EN.
module tb_dispatcher_arbiter;

    localparam int NQ = 4;
    localparam int DS = 102 + (4 * 16) + (4 * 128);
    localparam int RS = 32;
    localparam int IW = $clog2(NQ);

    logic          clock = 1'b0;
    logic          reset;
    logic [DS-1:0] p1Packet, p2Packet;
    logic          p1Valid, p2Valid;
    logic [IW-1:0] p1Id, p2Id;
    logic          p1Ready, p2Ready;
    logic [NQ-1:0] queuesReady;
    logic [DS-1:0] outPacket;
    logic [NQ-1:0] outValid;
    logic [IW-1:0] outId;
    logic [RS-1:0] grant1, grant2, stalls;

    int compareCount  = 0;
    int mismatchCount = 0;
    int expGrant1 = 0, expGrant2 = 0, expStall = 0;
    int expCh;

    always #5 clock = ~clock;

    dispatcher_arbiter #(.NUMBER_OF_QUEUES(NQ), .DATA_SIZE(DS), .REGISTER_SIZE(RS)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .packetizer_1_packet         (p1Packet),
        .packetizer_1_valid          (p1Valid),
        .packetizer_1_id             (p1Id),
        .packetizer_1_ready          (p1Ready),
        .packetizer_2_packet         (p2Packet),
        .packetizer_2_valid          (p2Valid),
        .packetizer_2_id             (p2Id),
        .packetizer_2_ready          (p2Ready),
        .queues_ready                (queuesReady),
        .dispatcher_to_queues_packet (outPacket),
        .dispatcher_to_queues_valid  (outValid),
        .dispatcher_to_queues_id     (outId),
        .grant_count_1               (grant1),
        .grant_count_2               (grant2),
        .stall_count                 (stalls)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v1, input logic [IW-1:0] id1, input logic [31:0] pk1,
                                 input logic v2, input logic [IW-1:0] id2, input logic [31:0] pk2,
                                 input logic [NQ-1:0] qr);
        p1Valid = v1; p1Id = id1; p1Packet = DS'(pk1);
        p2Valid = v2; p2Id = id2; p2Packet = DS'(pk2);
        queuesReady = qr;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkCounters(input string tag);
`ifdef DISPATCHER_ARBITER_STATS_EN
        checkOutput({tag, "_g1"}, 64'(grant1), 64'(expGrant1));
        checkOutput({tag, "_g2"}, 64'(grant2), 64'(expGrant2));
        checkOutput({tag, "_st"}, 64'(stalls), 64'(expStall));
`else
        checkOutput({tag, "_g1"}, 64'(grant1), 64'd0);
        checkOutput({tag, "_g2"}, 64'(grant2), 64'd0);
        checkOutput({tag, "_st"}, 64'(stalls), 64'd0);
`endif
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 4'hF);
        tick(); tick();
        reset = 1'b1;
        #1;

        // Idle after reset
        checkOutput("idle_valid", 64'(outValid), 64'h0);
        checkOutput("idle_pkt", 64'(outPacket[31:0]), 64'h0);
        checkOutput("idle_id", 64'(outId), 64'h0);
        checkOutput("idle_r1", 64'(p1Ready), 64'h1);
        checkOutput("idle_r2", 64'(p2Ready), 64'h0);
        checkCounters("idle");

        // Both channels contend every cycle: grants alternate starting with CH1
        applyStimulus(1, 2'd1, 32'hA1, 1, 2'd2, 32'hB2, 4'hF);
        expCh = 1;
        for (int i = 0; i < 6; i++) begin
            checkOutput("alt_r1", 64'(p1Ready), 64'(expCh == 1));
            checkOutput("alt_r2", 64'(p2Ready), 64'(expCh == 2));
            tick();
            checkOutput("alt_valid", 64'(outValid), (expCh == 1) ? 64'h2 : 64'h4);
            checkOutput("alt_pkt", 64'(outPacket[31:0]), (expCh == 1) ? 64'hA1 : 64'hB2);
            expCh = (expCh == 1) ? 2 : 1;
        end
        expGrant1 += 3; expGrant2 += 3;
        applyStimulus(0, 0, 0, 0, 0, 0, 4'hF);
        tick();
        checkOutput("alt_empty", 64'(outValid), 64'h0);
        checkCounters("alt");

        // CH1 to queue 3 while queue 3 is full for 5 cycles
        applyStimulus(1, 2'd3, 32'hC1, 0, 0, 0, 4'b0111);
        checkOutput("stall_r1_pre", 64'(p1Ready), 64'h1);
        tick();
        expGrant1 += 1;
        checkOutput("stall_load", 64'(outValid), 64'h8);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_hold", 64'(outValid), 64'h8);
            checkOutput("stall_pkt", 64'(outPacket[31:0]), 64'hC1);
            checkOutput("stall_r1", 64'(p1Ready), 64'h0);
        end
        expStall += 5;
        applyStimulus(1, 2'd3, 32'hC2, 0, 0, 0, 4'hF);
        checkOutput("drainload_r1", 64'(p1Ready), 64'h1);
        tick();
        expGrant1 += 1;
        checkOutput("drainload_valid", 64'(outValid), 64'h8);
        checkOutput("drainload_pkt", 64'(outPacket[31:0]), 64'hC2);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'hF);
        tick();
        checkOutput("stall_empty", 64'(outValid), 64'h0);
        checkCounters("stall");

        // Queue 0 blocked: CH2 aimed at queue 1 must wait (no bypass)
        applyStimulus(1, 2'd0, 32'hD1, 0, 0, 0, 4'b1110);
        tick();
        expGrant1 += 1;
        checkOutput("hol_load", 64'(outValid), 64'h1);
        applyStimulus(0, 0, 0, 1, 2'd1, 32'hE2, 4'b1110);
        for (int i = 0; i < 3; i++) begin
            checkOutput("hol_r2", 64'(p2Ready), 64'h0);
            tick();
            checkOutput("hol_hold", 64'(outValid), 64'h1);
        end
        expStall += 3;
        applyStimulus(0, 0, 0, 1, 2'd1, 32'hE2, 4'hF);
        checkOutput("hol_r2_free", 64'(p2Ready), 64'h1);
        tick();
        expGrant2 += 1;
        checkOutput("hol_ch2", 64'(outValid), 64'h2);
        checkOutput("hol_pkt", 64'(outPacket[31:0]), 64'hE2);
        checkOutput("hol_id", 64'(outId), 64'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'hF);
        tick();
        checkCounters("hol");

        // Reset while the stage holds a CH1 packet; CH1 must still win first afterwards
        applyStimulus(1, 2'd0, 32'hF1, 0, 0, 0, 4'b1110);
        tick();
        checkOutput("rst_full", 64'(outValid), 64'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'hF);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        expGrant1 = 0; expGrant2 = 0; expStall = 0;
        checkOutput("rst_valid", 64'(outValid), 64'h0);
        checkOutput("rst_pkt", 64'(outPacket[31:0]), 64'h0);
        checkCounters("rst");
        applyStimulus(1, 2'd2, 32'h111, 1, 2'd3, 32'h222, 4'hF);
        checkOutput("rst_r1", 64'(p1Ready), 64'h1);
        checkOutput("rst_r2", 64'(p2Ready), 64'h0);

        // 14 contended transfers then 3 CH1-only: 10 CH1 and 7 CH2 grants
        for (int i = 0; i < 14; i++) tick();
        checkOutput("cnt_last", 64'(outPacket[31:0]), 64'h222);
        applyStimulus(1, 2'd2, 32'h333, 0, 0, 0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            checkOutput("cnt_r1", 64'(p1Ready), 64'h1);
            tick();
        end
        checkOutput("cnt_pkt", 64'(outPacket[31:0]), 64'h333);
        checkOutput("cnt_valid", 64'(outValid), 64'h4);
        expGrant1 = 10; expGrant2 = 7;
        applyStimulus(0, 0, 0, 0, 0, 0, 4'hF);
        tick();
        checkCounters("cnt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/dispatcher_arbiter.md
Name: dispatcher_arbiter

Overview:
- Shares the single queue-write port of the queueing domain between the two packetizers. Replaces the OR-merge of both packetizer channels.
- Performs round-robin arbitration between packetizer 1 and packetizer 2 and registers the winner in a one-entry output stage.
- Presents the packet to the target queue with a one-hot per-queue valid, and holds it until that queue is ready (not full).

Parameters:
- NUMBER_OF_QUEUES, 4, number of queues; power of two, >= 2.
- DATA_SIZE, 102+(4*16)+(4*128), packet width in bits.
- REGISTER_SIZE, 32, width of the statistics counters.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-low reset.
- packetizer_1_packet  in  DATA_SIZE  channel 1 packet.
- packetizer_1_valid  in  1  channel 1 valid.
- packetizer_1_id  in  $clog2(NUMBER_OF_QUEUES)  channel 1 target queue.
- packetizer_1_ready  out  1  channel 1 accepted this cycle.
- packetizer_2_packet / packetizer_2_valid / packetizer_2_id / packetizer_2_ready: same as channel 1, for channel 2.
- queues_ready  in  NUMBER_OF_QUEUES  per-queue "can accept" (that queue is not full).
- dispatcher_to_queues_packet  out  DATA_SIZE  registered packet.
- dispatcher_to_queues_valid  out  NUMBER_OF_QUEUES  one-hot valid at the target queue.
- dispatcher_to_queues_id  out  $clog2(NUMBER_OF_QUEUES)  registered target id.
- grant_count_1  out  REGISTER_SIZE  statistics (see Optional Feature).
- grant_count_2  out  REGISTER_SIZE  statistics.
- stall_count  out  REGISTER_SIZE  statistics.

Behaviour:
- State:
  - Output stage: EMPTY/FULL, held as flag stage_full.
  - Round-robin pointer last_grant ∈ {CH1, CH2}.
- Reset (reset==0 at a rising edge):
  - stage_full=0, all valids 0, packet=0, id=0, last_grant=CH2 (so CH1 wins the first contention).
  - Statistics counters = 0.
  - A packet held in the stage at reset is discarded.
- Drain condition: drain = stage_full && queues_ready[dispatcher_to_queues_id].
- Load enable: load_en = !stage_full || drain.
- Selection (combinational):
  - Both valid: select the channel that is not last_grant.
  - Exactly one valid: select that channel.
  - Neither valid: select the channel that is not last_grant.
- Ready: packetizer_X_ready = load_en && sel==X. The non-selected channel's ready is 0, even if it is valid.
- Handshake: transfer on valid && ready.
  - On transfer, at the edge: latch the packet and id, set stage_full=1, set last_grant=sel.
  - last_grant changes only on a transfer.
- Drain without a load: stage_full goes to 0 at the edge.
- Drain and load in the same cycle: the stage is overwritten. Sustained throughput is 1 packet/cycle.
- Latency: a packet accepted at edge N appears at the outputs after edge N; minimum 1 cycle.
- dispatcher_to_queues_valid = stage_full ? (1 << id) : 0. Driven from registers only, with no combinational path from inputs.
- Target queue not full == 0: the stage holds packet, id and valid stable until drained.
  - Both inputs are back-pressured (ready=0). No head-of-line bypass to other queues.
- Inputs must hold packet/id stable while valid && !ready. The block does not check this.
- Packet and id register contents are held (not cleared) when the stage empties.

Optional Feature:
- Macro: DISPATCHER_ARBITER_STATS_EN.
- Defined:
  - grant_count_1 and grant_count_2 increment on each transfer from their channel.
  - stall_count increments each cycle with stage_full && !drain.
  - All three counters saturate at 2^REGISTER_SIZE-1 (no wrap) and are cleared by reset.
- Undefined: the counter logic is not compiled. The three ports remain and are tied to 0.

Decomposition:
- Shared package memoredf_pkg:
  - typedef channel_t enum {CH1, CH2}.
  - Function onehot_queue(id).
  - Localparam QUEUE_ID_WIDTH = $clog2(NUMBER_OF_QUEUES).
- One natural sub-module, rr_arbiter_2: selection logic plus the last_grant register, with inputs valid[1:0] and advance, and output sel.
- The output stage and the statistics counters stay in dispatcher_arbiter.

Test Plan:
- Reset then idle, all queues_ready=1:
  - All valids 0; packetizer_1_ready=1, packetizer_2_ready=0.
  - Counters 0.
- Both channels valid every cycle, ids 1 and 2, queues_ready=4'hF:
  - Grants alternate CH1, CH2, CH1, …
  - dispatcher_to_queues_valid alternates 4'b0010 / 4'b0100 every cycle from cycle 1.
- CH1 only, id=3, queues_ready[3]=0 for 5 cycles, then 1:
  - Stage holds with valid=4'b1000 for 5 cycles; packetizer_1_ready=0.
  - Drain and a new load occur in the same cycle once queues_ready[3]=1.
  - With stats enabled, stall_count=5.
- Queue 0 not ready while CH2 targets queue 1: CH2 is blocked (no bypass) until the packet for queue 0 drains.
- Reset asserted while stage_full=1:
  - Next cycle, valid=0 and the packet is lost.
  - With both channels valid, the first grant goes to CH1.
- DISPATCHER_ARBITER_STATS_EN defined, 10 CH1 and 7 CH2 transfers: grant_count_1=10, grant_count_2=7. Without the macro, all three counters read 0.
